// File: rtl/riscv_irq_event_unit.sv
// rtl/riscv_irq_event_unit.sv - interrupt front-end: synchroniser, edge detect, pending/mask registers
// Feeds the exception controller's level irq_i vector from raw asynchronous sources.
module riscv_irq_event_unit #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq_src_i,
  output logic [31:0] irq_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_gnt_o,
  output logic        reg_rvalid_o,
  output logic [31:0] reg_rdata_o
);

  typedef enum logic {IDLE, RESP} state_t;

  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] sync, prev_q, pending_q, mask_q, mode_q;
  logic [31:0] rise, sw_set, sw_clr, ack_match, edge_next, pending_d, read_mux;
  logic [1:0]  sel;
  logic        wr;
  logic        unused_addr;
  state_t      state_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  assign sync        = sync_q[SYNC_STAGES-1];
  assign rise        = sync & ~prev_q;
  assign sel         = reg_addr_i[3:2];
  assign wr          = reg_req_i & reg_we_i;
  assign unused_addr = ^reg_addr_i[1:0];

  assign sw_set    = (wr && sel == 2'd1) ? reg_wdata_i : 32'h0;
  assign sw_clr    = (wr && sel == 2'd2) ? reg_wdata_i : 32'h0;
  assign ack_match = irq_ack_i ? (32'd1 << irq_id_i) : 32'h0;

  // Set terms are ORed in after the clear so a coincident edge is never lost.
  assign edge_next = rise | sw_set | (pending_q & ~(ack_match | sw_clr));
  assign pending_d = (mode_q & edge_next) | (~mode_q & sync);

  assign irq_o        = pending_q & mask_q;
  assign reg_gnt_o    = reg_req_i;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;

  always_comb begin
    read_mux = 32'h0;
    case (sel)
      2'd0:    read_mux = mask_q;
      2'd1:    read_mux = pending_q;
      2'd2:    read_mux = 32'h0;
      default: read_mux = mode_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= 32'h0;
      pending_q <= 32'h0;
      mask_q    <= RESET_MASK;
      mode_q    <= 32'h0;
    end else begin
      if (SYNC_STAGES > 1) begin
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
      sync_q[0] <= irq_src_i;
      prev_q    <= sync;
      pending_q <= pending_d;
      if (wr && sel == 2'd0) mask_q <= reg_wdata_i;
      if (wr && sel == 2'd3) mode_q <= reg_wdata_i;
    end
  end

  // Read data is captured at grant, before this cycle's writes or acks land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reg_req_i) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= reg_we_i ? 32'h0 : read_mux;
          end else begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
          end
        end
        RESP: begin
          if (reg_req_i) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= reg_we_i ? 32'h0 : read_mux;
          end else begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
          rdata_q  <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_irq_event_unit.sv
// tb/tb_riscv_irq_event_unit.sv - scoreboard bench for riscv_irq_event_unit
// Reference model follows the register/pending rules bit by bit; a monitor compares every cycle.
module tb_riscv_irq_event_unit;

  localparam int          SYNC  = 2;
  localparam logic [31:0] RMASK = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_src = 32'h0;
  logic [31:0] irq_o;
  logic        irq_ack = 1'b0;
  logic [4:0]  irq_id = 5'd0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_hist[$];
  logic [31:0] m_prev = 32'h0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] m_mask = RMASK;
  logic [31:0] m_mode = 32'h0;
  logic [31:0] exp_q[$];

  riscv_irq_event_unit #(.SYNC_STAGES(SYNC), .RESET_MASK(RMASK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_src_i    (irq_src),
    .irq_o        (irq_o),
    .irq_ack_i    (irq_ack),
    .irq_id_i     (irq_id),
    .reg_req_i    (req),
    .reg_we_i     (we),
    .reg_addr_i   (addr),
    .reg_wdata_i  (wdata),
    .reg_gnt_o    (gnt),
    .reg_rvalid_o (rvalid),
    .reg_rdata_o  (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: sync is the source value seen SYNC edges ago.
  initial begin : model
    logic [31:0] sync, rise, sw_set, sw_clr, ackm, nxt;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(32'h0);
        m_prev = 32'h0;
        m_pend = 32'h0;
        m_mask = RMASK;
        m_mode = 32'h0;
        exp_q  = {};
      end else begin
        sync   = m_hist[SYNC-1];
        rise   = sync & ~m_prev;
        sw_set = 32'h0;
        sw_clr = 32'h0;
        ackm   = 32'h0;
        if (req && we && addr[3:2] == 2'd1) sw_set = wdata;
        if (req && we && addr[3:2] == 2'd2) sw_clr = wdata;
        if (irq_ack) ackm[irq_id] = 1'b1;
        if (req) begin
          if (we) exp_q.push_back(32'h0);
          else begin
            case (addr[3:2])
              2'd0:    exp_q.push_back(m_mask);
              2'd1:    exp_q.push_back(m_pend);
              2'd2:    exp_q.push_back(32'h0);
              default: exp_q.push_back(m_mode);
            endcase
          end
        end
        for (int i = 0; i < 32; i++) begin
          if (m_mode[i]) begin
            if (rise[i] || sw_set[i])      nxt[i] = 1'b1;
            else if (ackm[i] || sw_clr[i]) nxt[i] = 1'b0;
            else                           nxt[i] = m_pend[i];
          end else begin
            nxt[i] = sync[i];
          end
        end
        m_pend = nxt;
        if (req && we && addr[3:2] == 2'd0) m_mask = wdata;
        if (req && we && addr[3:2] == 2'd3) m_mode = wdata;
        m_prev = sync;
        m_hist.push_front(irq_src);
        void'(m_hist.pop_back());
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      check("irq_o", irq_o, m_pend & m_mask);
      check("gnt", {31'h0, gnt}, {31'h0, req});
      check("rvalid", {31'h0, rvalid}, {31'h0, (exp_q.size() > 0)});
      if (rvalid && exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_op(input logic w, input logic [3:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_ack(input logic [4:0] id);
    irq_ack = 1'b1; irq_id = id;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("reset_irq_o", irq_o, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Level line latency, both directions
    reg_op(1'b1, 4'h0, 32'h0000_0008);
    irq_src[3] = 1'b1;
    tick(); tick();
    check("t1_rise_early", {31'h0, irq_o[3]}, 32'h0);
    tick();
    check("t1_rise", {31'h0, irq_o[3]}, 32'h1);
    irq_src[3] = 1'b0;
    tick(); tick();
    check("t1_fall_early", {31'h0, irq_o[3]}, 32'h1);
    tick();
    check("t1_fall", {31'h0, irq_o[3]}, 32'h0);

    // Edge line holds a short pulse until acknowledged
    reg_op(1'b1, 4'hC, 32'h0000_0080);
    reg_op(1'b1, 4'h0, 32'hFFFF_FFFF);
    irq_src[7] = 1'b1;
    tick();
    irq_src[7] = 1'b0;
    repeat (5) tick();
    check("t2_held", {31'h0, irq_o[7]}, 32'h1);
    do_ack(5'd7);
    check("t2_acked", {31'h0, irq_o[7]}, 32'h0);

    // Coincident rise and ack: set wins
    reg_op(1'b1, 4'hC, 32'h0000_00A0);
    reg_op(1'b1, 4'h4, 32'h0000_0020);
    irq_src[5] = 1'b1;
    tick(); tick();
    do_ack(5'd5);
    check("t3_set_wins", {31'h0, irq_o[5]}, 32'h1);

    // Ack clears only the serviced bit
    reg_op(1'b1, 4'hC, 32'h0000_02B0);
    reg_op(1'b1, 4'h8, 32'hFFFF_FFFF);
    reg_op(1'b1, 4'h4, 32'h0000_0210);
    do_ack(5'd4);
    reg_op(1'b0, 4'h4, 32'h0);
    @(negedge clk);
    check("t4_pending", rdata, 32'h0000_0200);
    #1;

    // Software trigger gated by mask
    irq_src = 32'h0;
    repeat (4) tick();
    reg_op(1'b1, 4'hC, 32'hFFFF_FFFF);
    reg_op(1'b1, 4'h0, 32'h0);
    reg_op(1'b1, 4'h8, 32'hFFFF_FFFF);
    reg_op(1'b1, 4'h4, 32'h8000_0001);
    tick();
    check("t5_masked", irq_o, 32'h0);
    reg_op(1'b1, 4'h0, 32'hFFFF_FFFF);
    check("t5_unmasked", irq_o, 32'h8000_0001);

    // Back-to-back accesses, then reset during a response
    req = 1'b1; we = 1'b0; addr = 4'h0;
    tick();
    req = 1'b1; we = 1'b1; addr = 4'h8; wdata = 32'h0;
    @(negedge clk);
    check("t6_rv1", {31'h0, rvalid}, 32'h1);
    check("t6_rdata1", rdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("t6_rv2", {31'h0, rvalid}, 32'h1);
    check("t6_rdata2", rdata, 32'h0);
    @(posedge clk);
    #1;
    reg_op(1'b0, 4'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("t6_reset_irq_o", irq_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomised traffic against the model
    for (int n = 0; n < 2000; n++) begin
      irq_src = irq_src ^ ($urandom & $urandom & $urandom);
      req     = ($urandom_range(1, 0) == 1);
      we      = ($urandom_range(1, 0) == 1);
      addr    = 4'($urandom_range(15, 0));
      wdata   = $urandom;
      irq_ack = ($urandom_range(3, 0) == 0);
      irq_id  = 5'($urandom_range(31, 0));
      if (n == 1000) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end
    req = 1'b0; we = 1'b0; irq_ack = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
